// File: rtl/mx_block_serializer.sv
// MX block serializer: captures one k-element block plus shared exponent
// and streams it out as k/lanes beats over a valid/ready interface.
module mx_block_serializer #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [k-1:0][bit_width-1:0]        i_mx_vec,
    input  logic [7:0]                         i_mx_exp,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [lanes*bit_width-1:0]         o_data,
    output logic [7:0]                         o_exp,
    output logic                               o_first,
    output logic                               o_last
);

    localparam int NB     = k / lanes;
    localparam int BW_B   = (NB > 1) ? $clog2(NB) : 1;
    localparam int BEAT_W = lanes * bit_width;

    if (k % lanes != 0) begin : g_bad_cfg
        $error("mx_block_serializer: k must be a multiple of lanes");
    end

    typedef enum logic {
        EMPTY,
        SEND
    } state_e;

    state_e                 state_q;
    logic [k*bit_width-1:0] hold_q;
    logic [BW_B-1:0]        b_q;
    logic [BW_B-1:0]        b_d;
    logic                   accept;
    logic                   xfer;

    assign o_valid = (state_q == SEND);
    assign xfer    = o_valid && i_ready;
    // Final beat leaving frees the holding register in the same cycle.
    assign o_ready = i_rst_n && ((state_q == EMPTY) || (xfer && o_last));
    assign accept  = i_valid && o_ready;
    assign b_d     = b_q + BW_B'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            b_q     <= '0;
            o_data  <= '0;
            o_exp   <= '0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else if (accept) begin
            state_q <= SEND;
            hold_q  <= i_mx_vec;
            b_q     <= '0;
            o_data  <= i_mx_vec[lanes-1:0];
            o_exp   <= i_mx_exp;
            o_first <= 1'b1;
            o_last  <= (NB == 1);
        end else if (xfer) begin
            if (o_last) begin
                state_q <= EMPTY;
                o_first <= 1'b0;
                o_last  <= 1'b0;
            end else begin
                b_q     <= b_d;
                o_data  <= hold_q[int'(b_d)*BEAT_W +: BEAT_W];
                o_first <= 1'b0;
                o_last  <= (b_d == BW_B'(NB - 1));
            end
        end
    end

endmodule
